// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding for E and D, load/branch/MDU stall
// detection, an MDU busy timer and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int ADDR_WIDTH  = 5,
    parameter int MDU_LATENCY = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rsD,
    input  logic [ADDR_WIDTH-1:0] rtD,
    input  logic [ADDR_WIDTH-1:0] rsE,
    input  logic [ADDR_WIDTH-1:0] rtE,
    input  logic [ADDR_WIDTH-1:0] WriteRegE,
    input  logic                  RegWriteE,
    input  logic                  MemtoRegE,
    input  logic [ADDR_WIDTH-1:0] WriteRegM,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [ADDR_WIDTH-1:0] WriteRegW,
    input  logic                  RegWriteW,
    input  logic                  BranchD,
    input  logic                  MduStartE,
    input  logic                  MduReadD,
    input  logic                  StallCntClr,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  ForwardAD,
    output logic                  ForwardBD,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushE,
    output logic                  MduBusy,
    output logic [CNT_WIDTH-1:0]  StallCount
);

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG   = '0;
    localparam logic [7:0]            MDU_RELOAD = 8'(MDU_LATENCY - 1);

    logic [7:0] mdu_cnt;
    logic       lwstall;
    logic       branchstall;
    logic       mdustall;
    logic       stall;
    logic       e_hits_d;
    logic       m_hits_d;

    // M result takes priority over W because it is the younger write.
    always_comb begin
        ForwardAE = 2'b00;
        if (rsE != ZERO_REG && rsE == WriteRegM && RegWriteM)
            ForwardAE = 2'b10;
        else if (rsE != ZERO_REG && rsE == WriteRegW && RegWriteW)
            ForwardAE = 2'b01;
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (rtE != ZERO_REG && rtE == WriteRegM && RegWriteM)
            ForwardBE = 2'b10;
        else if (rtE != ZERO_REG && rtE == WriteRegW && RegWriteW)
            ForwardBE = 2'b01;
    end

    assign ForwardAD = (rsD != ZERO_REG) && (rsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (rtD != ZERO_REG) && (rtD == WriteRegM) && RegWriteM;

    assign e_hits_d = (WriteRegE != ZERO_REG) && (WriteRegE == rsD || WriteRegE == rtD);
    assign m_hits_d = (WriteRegM != ZERO_REG) && (WriteRegM == rsD || WriteRegM == rtD);

    assign lwstall     = MemtoRegE && RegWriteE && e_hits_d;
    // A branch compared in D cannot use an ALU result still in E, nor load data still in M.
    assign branchstall = BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d));
    assign MduBusy     = (mdu_cnt != 8'd0) || MduStartE;
    assign mdustall    = MduReadD && MduBusy;
    assign stall       = lwstall || branchstall || mdustall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    // The issue cycle counts as the first busy cycle, so only LATENCY-1 remain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mdu_cnt <= 8'd0;
        else if (mdu_cnt != 8'd0)
            mdu_cnt <= mdu_cnt - 8'd1;
        else if (MduStartE)
            mdu_cnt <= MDU_RELOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            StallCount <= '0;
        else if (StallCntClr)
            StallCount <= '0;
        else if (StallD && StallCount != '1)
            StallCount <= StallCount + 1'b1;
    end

endmodule
